// File: rtl/arb_rr_16_ctrl.sv
// Purpose: 16-way round-robin ownership arbiter; one owner at a time with optional hold timeout.
// Latency: grant registered one edge after req is seen in IDLE; release/timeout exit takes one edge.
// Backpressure: the owner keeps the grant until rel or timeout; other requesters wait, and req changes are ignored in OWN.
module arb_rr_16_ctrl #(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    // "release" is a reserved word in SystemVerilog, so the owner's free strobe is named rel.
    input  logic        rel,
    output logic        gnt_valid,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_idx,
    output logic        timeout
);

    // Counter only needs to reach MAX_HOLD-1; keep at least one bit so MAX_HOLD of 0 or 1 still elaborates.
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   gnt_q, gnt_d;
    logic [3:0]    idx_q, idx_d;
    logic          timeout_q, timeout_d;

    logic          pick_found;
    logic [3:0]    pick_idx;
    logic [3:0]    cand;
    logic          hold_expired;

    // Round-robin search: first set req bit starting at ptr, wrapping modulo 16.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 4'd0;
        cand       = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Timeout fires on the last permitted owned cycle; MAX_HOLD of 0 means hold forever.
    assign hold_expired = (MAX_HOLD > 0) && (cnt_q == HOLD_LAST);

    // Next-state and next-output logic; outputs are computed here and registered below.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                // rel is meaningless without an owner and is simply not looked at here.
                if (pick_found) begin
                    state_d = OWN;
                    gnt_d   = 16'(1) << pick_idx;
                    idx_d   = pick_idx;
                    ptr_d   = pick_idx + 4'd1;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                // Release wins over a coincident timeout so a well-behaved owner never sees a pulse.
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = 16'h0000;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                end else if (hold_expired) begin
                    state_d   = IDLE;
                    gnt_d     = 16'h0000;
                    idx_d     = 4'd0;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 16'h0000;
                idx_d   = 4'd0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset drops any grant immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ptr_q     <= 4'd0;
            cnt_q     <= '0;
            gnt_q     <= 16'h0000;
            idx_q     <= 4'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == OWN);
    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_arb_rr_16_ctrl.sv
// Purpose: self-checking bench for arb_rr_16_ctrl with MAX_HOLD = 4.
// Latency: inputs driven 2 time units after each rising edge; outputs sampled on falling edges.
// Backpressure: none; every wait is a fixed number of clock cycles.
module tb_arb_rr_16_ctrl;

    localparam int MAXH = 4;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic        rel;
    logic        gnt_valid;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    arb_rr_16_ctrl #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .rel       (rel),
        .gnt_valid (gnt_valid),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner number (-1 = none), next-priority index, owned-cycle count.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < 16; k++) begin
                    if (m_owner < 0 && req[(m_ptr + k) % 16]) begin
                        m_owner = (m_ptr + k) % 16;
                    end
                end
                if (m_owner >= 0) begin
                    m_ptr  = (m_owner + 1) % 16;
                    m_held = 1;
                end
            end else if (rel) begin
                m_owner = -1;
            end else if (m_held == MAXH) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    end

    // Every falling edge: DUT outputs must match the model.
    always @(negedge clk) begin
        logic [15:0] e_gnt;
        e_gnt = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
        chk("model_gnt_valid", {31'd0, gnt_valid}, {31'd0, (m_owner >= 0)});
        chk("model_gnt", {16'd0, gnt}, {16'd0, e_gnt});
        chk("model_gnt_idx", {28'd0, gnt_idx}, (m_owner >= 0) ? m_owner : 0);
        chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_grant(input string name, input logic [3:0] idx);
        logic [15:0] oh;
        oh = 16'h0001 << idx;
        chk({name, "_valid"}, {31'd0, gnt_valid}, 32'd1);
        chk({name, "_idx"}, {28'd0, gnt_idx}, {28'd0, idx});
        chk({name, "_gnt"}, {16'd0, gnt}, {16'd0, oh});
    endtask

    task automatic expect_idle(input string name, input logic exp_to);
        chk({name, "_valid"}, {31'd0, gnt_valid}, 32'd0);
        chk({name, "_gnt"}, {16'd0, gnt}, 32'd0);
        chk({name, "_idx"}, {28'd0, gnt_idx}, 32'd0);
        chk({name, "_timeout"}, {31'd0, timeout}, {31'd0, exp_to});
    endtask

    initial begin
        reset = 1'b1;
        req   = 16'h0000;
        rel   = 1'b0;
        step(2);
        expect_idle("reset", 1'b0);
        reset = 1'b0;

        // Two requesters held: 0, then 4, then back to 0.
        req = 16'h0011;
        step(1);
        expect_grant("rr_first", 4'd0);
        rel = 1'b1;
        step(1);
        expect_idle("rr_rel1", 1'b0);
        rel = 1'b0;
        step(1);
        expect_grant("rr_second", 4'd4);
        rel = 1'b1;
        step(1);
        rel = 1'b0;
        step(1);
        expect_grant("rr_third", 4'd0);
        rel = 1'b1;
        req = 16'h0000;
        step(1);
        rel = 1'b0;

        // Granting 15 wraps the pointer to 0.
        req = 16'h8000;
        step(1);
        expect_grant("wrap_15", 4'd15);
        rel = 1'b1;
        req = 16'hFFFF;
        step(1);
        rel = 1'b0;
        step(1);
        expect_grant("wrap_0", 4'd0);
        rel = 1'b1;
        req = 16'h0000;
        step(1);
        rel = 1'b0;

        // No release: grant holds exactly MAXH cycles, then timeout pulses once.
        req = 16'h0002;
        step(1);
        expect_grant("to_start", 4'd1);
        step(3);
        expect_grant("to_last", 4'd1);
        chk("to_last_timeout", {31'd0, timeout}, 32'd0);
        step(1);
        expect_idle("to_drop", 1'b1);
        req = 16'h0000;
        step(1);
        expect_idle("to_after", 1'b0);

        // Release on the final permitted cycle is a normal exit.
        req = 16'h0002;
        step(1);
        expect_grant("rel_last_start", 4'd1);
        step(3);
        rel = 1'b1;
        req = 16'h0000;
        step(1);
        expect_idle("rel_last_exit", 1'b0);
        rel = 1'b0;

        // Owner 3 holds while req moves elsewhere; next grant is 8.
        req = 16'h0008;
        step(1);
        expect_grant("stable_start", 4'd3);
        req = 16'h0100;
        step(2);
        expect_grant("stable_hold", 4'd3);
        rel = 1'b1;
        step(1);
        rel = 1'b0;
        step(1);
        expect_grant("stable_next", 4'd8);

        // Reset between edges while owning: grant drops without a clock edge.
        reset = 1'b1;
        #1;
        expect_idle("async_reset", 1'b0);
        step(1);
        reset = 1'b0;
        req   = 16'h0006;
        step(1);
        expect_grant("post_reset", 4'd1);
        rel = 1'b1;
        req = 16'h0000;
        step(1);

        // rel asserted while idle is ignored; a request still wins.
        req = 16'h0080;
        step(1);
        expect_grant("idle_rel_ignored", 4'd7);
        step(1);
        rel = 1'b0;
        req = 16'h0000;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
